// File: rtl/mcp3008_pkg.sv
// Shared constants and FSM state encoding for the MCP3008 responder.
package mcp3008_pkg;

    localparam int CMD_BITS    = 4;
    localparam int DATA_BITS   = 10;
    localparam int NUM_CH      = 8;
    localparam int CH_IDX_BITS = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CMD        = 3'd2,
        NULL       = 3'd3,
        DATA       = 3'd4,
        TRAIL      = 3'd5
    } state_t;

endpackage

// File: rtl/mcp3008_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with rise/fall
// strobes taken on the synchronized value.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// SPI responder emulating an MCP3008 ADC: decodes the start/command bits and
// shifts back a null bit plus a 10-bit single-ended or saturated differential result.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | CS high (or not yet armed); MISO undriven
//   WAIT_START | CS low, skipping leading 0s on MOSI until the start bit
//   CMD        | shifting in SGL/DIFF, D2, D1, D0 on SCLK rising edges
//   NULL       | command captured; next SCLK fall drives the null bit
//   DATA       | driving result B9..B0 on SCLK falling edges
//   TRAIL      | result done; drive 0 until CS rises
module mcp3008_responder
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_CLK,
    input  logic                          spi_MOSI,
    input  logic                          mcp_CS,
    input  logic [NUM_CH*DATA_BITS-1:0]   ch_data,
    output logic                          spi_MISO,
    output logic                          spi_MISO_oe,
    output logic                          cmd_valid,
    output logic                          cmd_single,
    output logic [CH_IDX_BITS-1:0]        cmd_channel,
    output logic                          xfer_done,
    output logic                          xfer_abort
);

    localparam int CNT_W = $clog2((DATA_BITS > CMD_BITS) ? DATA_BITS : CMD_BITS);
    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    state_t state, state_nxt;

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic cs_q, cs_rise, cs_fall;

    logic [CNT_W-1:0]      bit_cnt;
    logic [CMD_BITS-2:0]   cmd_sr;
    logic [DATA_BITS-1:0]  result_sr;
    logic [SET_W-1:0]      settle_cnt;
    logic                  cs_armed;

    logic cnt_load_cmd, cnt_load_data, cnt_dec;
    logic cmd_shift, cmd_capture, data_shift;
    logic miso_nxt, done_nxt, abort_nxt;

    logic [CH_IDX_BITS-1:0] sel_ch, neg_ch;
    logic [DATA_BITS-1:0]   in_pos, in_neg, result_nxt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_CLK),
        .q    (sclk_q_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_MOSI),
        .q    (mosi_q),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (mcp_CS),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // D0 is still on mosi_q in the capture cycle; the other fields are in cmd_sr.
    assign sel_ch = {cmd_sr[CMD_BITS-3:0], mosi_q};
    assign neg_ch = {sel_ch[CH_IDX_BITS-1:1], ~sel_ch[0]};
    assign in_pos = ch_data[int'(sel_ch)*DATA_BITS +: DATA_BITS];
    assign in_neg = ch_data[int'(neg_ch)*DATA_BITS +: DATA_BITS];

    always_comb begin
        result_nxt = '0;
        if (cmd_sr[CMD_BITS-2]) begin
            result_nxt = in_pos;
        end else if (in_pos >= in_neg) begin
            result_nxt = in_pos - in_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:       if (cs_fall && cs_armed)            state_nxt = WAIT_START;
                WAIT_START: if (sclk_rise && mosi_q)            state_nxt = CMD;
                CMD:        if (sclk_rise && bit_cnt == '0)     state_nxt = NULL;
                NULL:       if (sclk_fall)                      state_nxt = DATA;
                DATA:       if (sclk_fall && bit_cnt == '0)     state_nxt = TRAIL;
                TRAIL:      state_nxt = TRAIL;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_load_cmd  = 1'b0;
        cnt_load_data = 1'b0;
        cnt_dec       = 1'b0;
        cmd_shift     = 1'b0;
        cmd_capture   = 1'b0;
        data_shift    = 1'b0;
        miso_nxt      = spi_MISO;
        done_nxt      = 1'b0;
        abort_nxt     = 1'b0;
        if (cs_rise) begin
            miso_nxt  = 1'b0;
            done_nxt  = (state == TRAIL);
            abort_nxt = (state inside {CMD, NULL, DATA});
        end else begin
            case (state)
                IDLE: miso_nxt = 1'b0;
                WAIT_START: begin
                    if (sclk_rise && mosi_q) cnt_load_cmd = 1'b1;
                end
                CMD: begin
                    if (sclk_rise) begin
                        if (bit_cnt == '0) begin
                            cmd_capture = 1'b1;
                        end else begin
                            cmd_shift = 1'b1;
                            cnt_dec   = 1'b1;
                        end
                    end
                end
                NULL: begin
                    if (sclk_fall) begin
                        miso_nxt      = 1'b0;
                        cnt_load_data = 1'b1;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_nxt   = result_sr[DATA_BITS-1];
                        data_shift = 1'b1;
                        cnt_dec    = (bit_cnt != '0);
                    end
                end
                TRAIL: begin
                    if (sclk_fall) miso_nxt = 1'b0;
                end
                default: miso_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            result_sr   <= '0;
            spi_MISO    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_single  <= 1'b0;
            cmd_channel <= '0;
            xfer_done   <= 1'b0;
            xfer_abort  <= 1'b0;
        end else begin
            spi_MISO   <= miso_nxt;
            cmd_valid  <= cmd_capture;
            xfer_done  <= done_nxt;
            xfer_abort <= abort_nxt;
            if (cnt_load_cmd) begin
                bit_cnt <= CNT_W'(CMD_BITS - 1);
            end else if (cnt_load_data) begin
                bit_cnt <= CNT_W'(DATA_BITS - 1);
            end else if (cnt_dec) begin
                bit_cnt <= bit_cnt - CNT_W'(1);
            end
            if (cmd_shift) begin
                cmd_sr <= {cmd_sr[CMD_BITS-3:0], mosi_q};
            end
            if (cmd_capture) begin
                cmd_single  <= cmd_sr[CMD_BITS-2];
                cmd_channel <= sel_ch;
                result_sr   <= result_nxt;
            end else if (data_shift) begin
                result_sr <= {result_sr[DATA_BITS-2:0], 1'b0};
            end
        end
    end

    // The CS synchronizer comes out of reset reading "high" regardless of the
    // pin, so a CS held low across reset would look like a fresh falling edge.
    // Only accept a start once the chain holds real samples showing CS high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= SET_W'(SYNC_STAGES);
            cs_armed   <= 1'b0;
        end else begin
            if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
            if (!cs_armed && cs_q && settle_cnt == '0) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign spi_MISO_oe = (state != IDLE) && !cs_q;

endmodule
